// File: rtl/alu_status_flags_if.sv
// alu_status_flags_if: flag-write, software-write and branch-evaluation signals of alu_status_flags
//   master: drives flag_we/flag_arith/ALU flags, sr_we/sr_wdata, br_req/br_cond; observes flag and branch outputs
//   slave : the flag register itself
interface alu_status_flags_if;
  logic       flag_we;
  logic       flag_arith;
  logic       zero_in;
  logic       positive_in;
  logic       carry_in;
  logic       overflow_in;
  logic       sr_we;
  logic [3:0] sr_wdata;
  logic       br_req;
  logic [2:0] br_cond;
  logic [3:0] flags;
  logic [3:0] flags_valid;
  logic       br_valid;
  logic       br_taken;
  logic       br_fault;
  modport master (
    output flag_we, flag_arith, zero_in, positive_in, carry_in, overflow_in,
    output sr_we, sr_wdata, br_req, br_cond,
    input  flags, flags_valid, br_valid, br_taken, br_fault
  );
  modport slave (
    input  flag_we, flag_arith, zero_in, positive_in, carry_in, overflow_in,
    input  sr_we, sr_wdata, br_req, br_cond,
    output flags, flags_valid, br_valid, br_taken, br_fault
  );
endinterface

// File: rtl/alu_status_flags.sv
// alu_status_flags: status-flag register ({V,C,P,Z}) with per-flag valid bits and registered branch evaluator
//   clk, rst_n (async, active-low); bus: alu_status_flags_if.slave
module alu_status_flags (
  input logic clk,
  input logic rst_n,
  alu_status_flags_if.slave bus
);
  logic [3:0] flags_d, flags_q, valid_d, valid_q;
  logic [1:0] idx;
  logic [2:0] cm1;
  logic       fault, taken;
  logic       br_valid_q, br_taken_q, br_fault_q;
  // Non-arithmetic capture selects constants for C/V so X on carry_in/overflow_in never propagates.
  always_comb begin
    flags_d = bus.sr_we ? bus.sr_wdata :
              bus.flag_we ? (bus.flag_arith ? {bus.overflow_in, bus.carry_in, bus.positive_in, bus.zero_in}
                                            : {2'b00, bus.positive_in, bus.zero_in}) : flags_q;
    valid_d = bus.sr_we ? 4'b1111 :
              bus.flag_we ? (bus.flag_arith ? 4'b1111 : 4'b0011) : valid_q;
  end
  // Codes pair up per flag (1/2 Z, 3/4 P, 5/6 C, 7 V); even codes test the inverted flag.
  always_comb begin
    cm1   = bus.br_cond - 3'd1;
    idx   = cm1[2:1];
    fault = (bus.br_cond != 3'd0) && !valid_d[idx];
    taken = (bus.br_cond == 3'd0) || (!fault && (flags_d[idx] ^ ~bus.br_cond[0]));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= 4'b0000;
      valid_q    <= 4'b0000;
      br_valid_q <= 1'b0;
      br_taken_q <= 1'b0;
      br_fault_q <= 1'b0;
    end else begin
      flags_q    <= flags_d;
      valid_q    <= valid_d;
      br_valid_q <= bus.br_req;
      br_taken_q <= bus.br_req & taken;
      br_fault_q <= bus.br_req & fault;
    end
  end
  assign bus.flags       = flags_q;
  assign bus.flags_valid = valid_q;
  assign bus.br_valid    = br_valid_q;
  assign bus.br_taken    = br_taken_q;
  assign bus.br_fault    = br_fault_q;
endmodule

// File: tb/tb_alu_status_flags.sv
// tb_alu_status_flags: directed plus randomized checks of alu_status_flags against a named-flag reference model
module tb_alu_status_flags;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  alu_status_flags_if bus ();
  alu_status_flags dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic mz, mp, mc, mv, vz, vp, vc, vv;
  logic m_bv, m_bt, m_bf;
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".flags"}, bus.flags, {mv, mc, mp, mz});
    chk({tag, ".valid"}, bus.flags_valid, {vv, vc, vp, vz});
    chk({tag, ".br_valid"}, {3'b000, bus.br_valid}, {3'b000, m_bv});
    chk({tag, ".br_taken"}, {3'b000, bus.br_taken}, {3'b000, m_bt});
    chk({tag, ".br_fault"}, {3'b000, bus.br_fault}, {3'b000, m_bf});
  endtask
  task automatic model_reset();
    {mz, mp, mc, mv, vz, vp, vc, vv} = '0;
    {m_bv, m_bt, m_bf} = '0;
  endtask
  task automatic drive(input logic sr, input logic [3:0] wd, input logic fw, input logic fa,
                       input logic [3:0] alu, input logic br, input logic [2:0] cc);
    bus.sr_we       = sr;
    bus.sr_wdata    = wd;
    bus.flag_we     = fw;
    bus.flag_arith  = fa;
    bus.zero_in     = alu[0];
    bus.positive_in = alu[1];
    bus.carry_in    = fa ? alu[2] : 1'bx;
    bus.overflow_in = fa ? alu[3] : 1'bx;
    bus.br_req      = br;
    bus.br_cond     = cc;
  endtask
  task automatic cyc(input string tag, input logic sr, input logic [3:0] wd, input logic fw,
                     input logic fa, input logic [3:0] alu, input logic br, input logic [2:0] cc);
    logic z, p, c, v, okz, okp, okc, okv, f, t;
    drive(sr, wd, fw, fa, alu, br, cc);
    {z, p, c, v} = {mz, mp, mc, mv};
    {okz, okp, okc, okv} = {vz, vp, vc, vv};
    if (sr) begin
      {v, c, p, z} = wd;
      {okz, okp, okc, okv} = 4'b1111;
    end else if (fw && fa) begin
      {v, c, p, z} = alu;
      {okz, okp, okc, okv} = 4'b1111;
    end else if (fw) begin
      z = alu[0]; p = alu[1]; c = 1'b0; v = 1'b0;
      okz = 1'b1; okp = 1'b1; okc = 1'b0; okv = 1'b0;
    end
    case (cc)
      3'd0: begin t = 1'b1; f = 1'b0; end
      3'd1: begin t = z;    f = !okz; end
      3'd2: begin t = !z;   f = !okz; end
      3'd3: begin t = p;    f = !okp; end
      3'd4: begin t = !p;   f = !okp; end
      3'd5: begin t = c;    f = !okc; end
      3'd6: begin t = !c;   f = !okc; end
      default: begin t = v; f = !okv; end
    endcase
    @(posedge clk);
    #1;
    {mz, mp, mc, mv} = {z, p, c, v};
    {vz, vp, vc, vv} = {okz, okp, okc, okv};
    m_bv = br;
    m_bt = br && t && !f;
    m_bf = br && f;
    check_all(tag);
  endtask
  initial begin
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive($urandom, 4'($urandom), $urandom, 1'b1, 4'($urandom), $urandom, 3'($urandom));
      @(posedge clk);
      #1;
      check_all("reset_hold");
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    check_all("reset_release");
    cyc("reset_eq", 0, 0, 0, 0, 4'b0000, 1, 3'd1);
    chk("reset_eq_fault", {3'b000, bus.br_fault}, 4'b0001);
    cyc("arith", 0, 0, 1, 1, 4'b1100, 1, 3'd5);
    chk("arith_flags", bus.flags, 4'b1100);
    chk("arith_taken", {3'b000, bus.br_taken}, 4'b0001);
    cyc("logic_x", 0, 0, 1, 0, 4'b0011, 1, 3'd6);
    chk("logic_x_known", {3'b000, $isunknown({bus.flags, bus.flags_valid, bus.br_taken, bus.br_fault})}, 4'b0000);
    chk("logic_x_valid", bus.flags_valid, 4'b0011);
    cyc("priority", 1, 4'b0101, 1, 1, 4'b1010, 0, 3'd0);
    chk("priority_flags", bus.flags, 4'b0101);
    cyc("b2b_set", 1, 4'b0001, 0, 0, 4'b0000, 0, 3'd0);
    cyc("b2b_eq", 0, 0, 0, 0, 0, 1, 3'd1);
    cyc("b2b_ne", 0, 0, 0, 0, 0, 1, 3'd2);
    cyc("b2b_al", 0, 0, 0, 0, 0, 1, 3'd0);
    cyc("b2b_mi", 0, 0, 0, 0, 0, 1, 3'd4);
    chk("b2b_mi_taken", {3'b000, bus.br_taken}, 4'b0001);
    cyc("idle", 0, 0, 0, 0, 0, 0, 3'd0);
    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom_range(0, 7) == 0), 4'($urandom), $urandom, $urandom,
          4'($urandom), $urandom, 3'($urandom));
    end
    drive(0, 0, 0, 0, 0, 1, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midflight_async");
    @(posedge clk);
    #1;
    check_all("midflight_edge");
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc("post_reset", 0, 0, 0, 0, 0, 1, 3'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
